// File: rtl/bus_demux_1to2.sv
// Single-outstanding 1-to-2 request demultiplexer: routes a request to target 0 or 1
// by address, returns the selected target's response, and forces an error on timeout.
module bus_demux_1to2 #(
    parameter logic [31:0] T1_BASE = 32'h8000_0000,
    parameter logic [31:0] T1_MASK = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        t0_valid_o,
    output logic        t1_valid_o,
    input  logic        t0_ready_i,
    input  logic        t1_ready_i,
    output logic [31:0] t_addr_o,
    output logic        t_we_o,
    output logic [31:0] t_wdata_o,
    output logic [3:0]  t_wstrb_o,
    input  logic        t0_resp_valid_i,
    input  logic        t1_resp_valid_i,
    input  logic [31:0] t0_rdata_i,
    input  logic [31:0] t1_rdata_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q;
    logic [31:0]   addr_q, wdata_q;
    logic          we_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          load;
    logic          tgt_ready, tgt_resp, expired;
    logic [31:0]   tgt_rdata;

    // Only the selected target's handshake and response are ever looked at.
    assign tgt_ready = sel_q ? t1_ready_i      : t0_ready_i;
    assign tgt_resp  = sel_q ? t1_resp_valid_i : t0_resp_valid_i;
    assign tgt_rdata = sel_q ? t1_rdata_i      : t0_rdata_i;
    // >= rather than == so a handshake in the expiry cycle still times out in WAIT.
    assign expired   = (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (tgt_ready) begin
                    state_d = S_WAIT;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (tgt_resp) begin
                    rdata_d = we_q ? 32'h0 : tgt_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (load) begin
                sel_q   <= ((req_addr_i & T1_MASK) == T1_BASE);
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
            end
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign t0_valid_o   = (state_q == S_REQ) && !sel_q;
    assign t1_valid_o   = (state_q == S_REQ) &&  sel_q;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign t_addr_o     = addr_q;
    assign t_we_o       = we_q;
    assign t_wdata_o    = wdata_q;
    assign t_wstrb_o    = wstrb_q;

endmodule

// File: tb/tb_bus_demux_1to2.sv
// Directed bench for bus_demux_1to2: routing, stalls, timeout, stray responses,
// mid-transaction reset and back-to-back requests.
module tb_bus_demux_1to2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        t0_valid_o, t1_valid_o, t0_ready_i, t1_ready_i;
    logic [31:0] t_addr_o, t_wdata_o;
    logic        t_we_o;
    logic [3:0]  t_wstrb_o;
    logic        t0_resp_valid_i, t1_resp_valid_i;
    logic [31:0] t0_rdata_i, t1_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    bus_demux_1to2 #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .t0_valid_o(t0_valid_o), .t1_valid_o(t1_valid_o),
        .t0_ready_i(t0_ready_i), .t1_ready_i(t1_ready_i),
        .t_addr_o(t_addr_o), .t_we_o(t_we_o), .t_wdata_o(t_wdata_o), .t_wstrb_o(t_wstrb_o),
        .t0_resp_valid_i(t0_resp_valid_i), .t1_resp_valid_i(t1_resp_valid_i),
        .t0_rdata_i(t0_rdata_i), .t1_rdata_i(t1_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws);
        req_valid_i = 1'b1; req_addr_i = a; req_we_i = we;
        req_wdata_i = wd; req_wstrb_i = ws;
        step();
        req_valid_i = 1'b0;
    endtask

    initial begin
        int cyc;
        int extra;
        reset = 1'b1;
        req_valid_i = 0; req_addr_i = 0; req_we_i = 0; req_wdata_i = 0; req_wstrb_i = 0;
        t0_ready_i = 0; t1_ready_i = 0; t0_resp_valid_i = 0; t1_resp_valid_i = 0;
        t0_rdata_i = 0; t1_rdata_i = 0;
        step(); step();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valids", {t0_valid_o, t1_valid_o, resp_valid_o, resp_err_o}, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_addr", t_addr_o, 0);
        reset = 1'b0;
        step();

        // 1: load to t0, ready immediately, response one cycle later
        issue(32'h0000_0040, 0, 0, 4'hF);
        chk("t1_valids", {t0_valid_o, t1_valid_o}, 2'b10);
        chk("t1_notready", req_ready_o, 0);
        chk("t1_addr", t_addr_o, 32'h0000_0040);
        t0_ready_i = 1;
        step();
        t0_ready_i = 0;
        chk("t1_wait_valid", {t0_valid_o, resp_valid_o}, 0);
        t0_resp_valid_i = 1; t0_rdata_i = 32'hDEAD_BEEF;
        step();
        t0_resp_valid_i = 0;
        chk("t1_resp", {resp_valid_o, resp_err_o}, 2'b10);
        chk("t1_rdata", resp_rdata_o, 32'hDEAD_BEEF);
        step();
        chk("t1_pulse_end", resp_valid_o, 0);
        chk("t1_hold", resp_rdata_o, 32'hDEAD_BEEF);
        chk("t1_idle_ready", req_ready_o, 1);

        // 2: store to t1 with three stall cycles
        issue(32'h8000_0010, 1, 32'h1234_5678, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            chk("t2_valids", {t0_valid_o, t1_valid_o}, 2'b01);
            chk("t2_wdata", t_wdata_o, 32'h1234_5678);
            chk("t2_ctl", {t_we_o, t_wstrb_o}, 5'b1_0011);
            if (i == 3) t1_ready_i = 1;
            step();
        end
        t1_ready_i = 0;
        chk("t2_wait_valids", {t0_valid_o, t1_valid_o}, 0);
        t1_resp_valid_i = 1; t1_rdata_i = 32'hCAFE_F00D;
        step();
        t1_resp_valid_i = 0;
        chk("t2_resp", {resp_valid_o, resp_err_o}, 2'b10);
        chk("t2_rdata", resp_rdata_o, 0);
        step();

        // 3: timeout on t1, late response ignored
        issue(32'h8000_0004, 0, 0, 4'hF);
        cyc = 0;
        while (!resp_valid_o && cyc < 20) begin
            step();
            cyc++;
        end
        chk("t3_latency", cyc, 8);
        chk("t3_err", {resp_valid_o, resp_err_o, t1_valid_o}, 3'b110);
        chk("t3_rdata", resp_rdata_o, 0);
        step(); step();
        t1_resp_valid_i = 1; t1_rdata_i = 32'h0BAD_0BAD;
        step();
        t1_resp_valid_i = 0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid_o) extra++;
            step();
        end
        chk("t3_no_late", extra, 0);
        chk("t3_err_hold", resp_err_o, 1);

        // 4: stray t1 response while waiting on t0
        issue(32'h0000_0100, 0, 0, 4'hF);
        t0_ready_i = 1;
        step();
        t0_ready_i = 0;
        t1_resp_valid_i = 1; t1_rdata_i = 32'hFFFF_FFFF;
        step();
        t1_resp_valid_i = 0;
        chk("t4_stray", resp_valid_o, 0);
        t0_resp_valid_i = 1; t0_rdata_i = 32'h0000_00AA;
        step();
        t0_resp_valid_i = 0;
        chk("t4_resp", {resp_valid_o, resp_err_o}, 2'b10);
        chk("t4_rdata", resp_rdata_o, 32'h0000_00AA);
        step();

        // 5: reset during WAIT, later response ignored, then normal request
        issue(32'h0000_0200, 0, 0, 4'hF);
        t0_ready_i = 1;
        step();
        t0_ready_i = 0;
        reset = 1;
        step();
        reset = 0;
        chk("t5_ready", req_ready_o, 1);
        chk("t5_valids", {t0_valid_o, t1_valid_o, resp_valid_o}, 0);
        t0_resp_valid_i = 1; t0_rdata_i = 32'h7777_7777;
        step();
        t0_resp_valid_i = 0;
        chk("t5_ignored", {resp_valid_o, req_ready_o}, 2'b01);
        issue(32'h0000_0000, 0, 0, 4'hF);
        chk("t5_new_valid", {t0_valid_o, t1_valid_o}, 2'b10);
        t0_ready_i = 1;
        step();
        t0_ready_i = 0;
        t0_resp_valid_i = 1; t0_rdata_i = 32'h0000_0055;
        step();
        t0_resp_valid_i = 0;
        chk("t5_resp", {resp_valid_o, resp_err_o}, 2'b10);
        chk("t5_rdata", resp_rdata_o, 32'h0000_0055);
        step();

        // 6: back-to-back with req_valid held high
        req_valid_i = 1; req_addr_i = 32'h0000_0300; req_we_i = 0;
        step();
        chk("t6_acc1", {req_ready_o, t0_valid_o, t1_valid_o}, 3'b010);
        req_addr_i = 32'h8000_0020;
        t0_ready_i = 1;
        step();
        t0_ready_i = 0;
        chk("t6_wait_ready", req_ready_o, 0);
        t0_resp_valid_i = 1; t0_rdata_i = 32'h0000_0011;
        step();
        t0_resp_valid_i = 0;
        chk("t6_resp1", {resp_valid_o, req_ready_o}, 2'b10);
        chk("t6_rdata1", resp_rdata_o, 32'h0000_0011);
        step();
        chk("t6_ready_back", {req_ready_o, resp_valid_o}, 2'b10);
        step();
        req_valid_i = 0;
        chk("t6_acc2", {req_ready_o, t0_valid_o, t1_valid_o}, 3'b001);
        chk("t6_addr2", t_addr_o, 32'h8000_0020);
        t1_ready_i = 1;
        step();
        t1_ready_i = 0;
        t1_resp_valid_i = 1; t1_rdata_i = 32'h0000_0022;
        step();
        t1_resp_valid_i = 0;
        chk("t6_resp2", {resp_valid_o, resp_err_o}, 2'b10);
        chk("t6_rdata2", resp_rdata_o, 32'h0000_0022);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_demux_1to2.md
Name: bus_demux_1to2

Overview:
- Routes one CPU-side memory request stream to one of two target ports by address, then returns that target's response to the initiator.
- It is the distribution counterpart of the datapath's 2-to-1 selection logic: one source fans out to two destinations instead of two sources merging into one.
- Sits between the RV32I load/store path and the memory system: target 0 is data RAM, target 1 is the MMIO/peripheral region.
- Allows at most one transaction in flight and has a timeout that guarantees the initiator always receives a response.

Parameters:
- T1_BASE, 32'h8000_0000, base address of the target-1 region.
- T1_MASK, 32'hFFFF_0000, address mask; target 1 is selected when (addr & T1_MASK) == T1_BASE, otherwise target 0.
- TIMEOUT, 255, cycles allowed in REQ+WAIT before an error response is forced (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  initiator request valid.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  32  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_wdata_i  in  32  store data.
- req_wstrb_i  in  4  byte-lane strobes.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  32  load data; 0 for stores and on error.
- resp_err_o  out  1  response is a timeout error.
- t0_valid_o, t1_valid_o  out  1 each  request valid to target 0 / target 1.
- t0_ready_i, t1_ready_i  in  1 each  target accepts the request.
- t_addr_o  out  32  registered address, shared by both targets.
- t_we_o  out  1  registered write enable, shared.
- t_wdata_o  out  32  registered store data, shared.
- t_wstrb_o  out  4  registered strobes, shared.
- t0_resp_valid_i, t1_resp_valid_i  in  1 each  target response valid.
- t0_rdata_i, t1_rdata_i  in  32 each  target read data.

Behaviour:
- Reset:
  - The FSM enters IDLE.
  - All outputs are 0 except req_ready_o, which is 1.
  - The timeout counter is cleared.
  - Reset asserted mid-transaction aborts it: no response is issued, target valids drop on the next edge, and any later target response is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o = 1 only in this state.
  - When req_valid_i = 1, the block registers addr, we, wdata, wstrb and the target select (sel) at the edge, then moves to REQ.
- REQ:
  - Drives t<sel>_valid_o = 1; the other target's valid stays 0. Shared t_* outputs hold the registered values.
  - Moves to WAIT on the first edge where the selected target's ready_i = 1.
  - t<sel>_valid_o stays high until that handshake; payload is stable throughout.
- WAIT:
  - Target valids are 0.
  - When t<sel>_resp_valid_i = 1, the block captures the selected target's rdata. The captured value is forced to 0 if t_we_o = 1. It then moves to RESP.
  - Responses are sampled only in WAIT. A target must respond at least 1 cycle after its ready handshake.
  - A response from the non-selected target is ignored in every state.
- RESP:
  - resp_valid_o = 1 for exactly one cycle, with resp_rdata_o and resp_err_o valid.
  - The FSM returns to IDLE on the next cycle.
  - resp_rdata_o and resp_err_o hold their values until the next response.
- Latency: request acceptance at edge N → target valid at N+1. With ready at N+1 and response at N+2, resp_valid_o is high in cycle N+3. A back-to-back request is accepted at earliest in cycle N+4.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle spent in REQ or WAIT.
  - When count == TIMEOUT-1 and no handshake or response occurs that cycle, the FSM goes to RESP with resp_err_o = 1, resp_rdata_o = 0, and target valids dropped.
  - If a response arrives in the same cycle the counter expires, the response wins and resp_err_o = 0.
  - A response arriving late, after a timeout, is ignored.
- Address decode: purely on the registered address. Sub-word alignment is the initiator's job; wstrb is passed through unchanged.

Test Plan:
- Load at 0x0000_0040; t0 ready on the first REQ cycle; t0 returns 0xDEAD_BEEF one cycle later → only t0_valid_o rises; resp_valid_o pulses once with rdata 0xDEAD_BEEF, err 0; total latency 3 cycles.
- Store at 0x8000_0010 with wdata 0x1234_5678 and wstrb 4'b0011; t1 holds ready low for 3 cycles → t1_valid_o is high 4 cycles with stable payload; t0_valid_o stays 0; response carries rdata 0 and err 0.
- Load at 0x8000_0004 with TIMEOUT = 8 and t1 never responding → resp_valid_o pulses with err 1 and rdata 0 after 8 REQ/WAIT cycles. A t1 response injected 2 cycles later produces no second resp_valid_o.
- Load to t0 while t1_resp_valid_i is pulsed with 0xFFFF_FFFF during WAIT, followed by t0 responding 0x0000_00AA → the response is 0x0000_00AA.
- Reset asserted during WAIT → after the edge, state is IDLE, req_ready_o = 1, and all valids are 0. A subsequent t0 response is ignored, and a new request to 0x0000_0000 completes normally.
- Two back-to-back requests, t0 then t1, with req_valid_i held high → req_ready_o is 0 from acceptance until the cycle after resp_valid_o. The second request is routed only to t1, and its responses arrive in order.
